// File: rtl/q_result_bcd_if.sv
// Handshake bundle between a Q-format result producer and the BCD formatter.
// The producer drives the i_* strobes and value; the formatter drives the o_* results.
`ifndef OUTPUTWIDTH
`define OUTPUTWIDTH 32
`endif

interface q_result_bcd_if #(
    parameter int M           = `OUTPUTWIDTH,
    parameter int FRAC        = 8,
    parameter int INT_DIGITS  = 8,
    parameter int FRAC_DIGITS = 3
);
    logic                       i_valid;
    logic                       i_error;
    logic [M-1:0]               i_val;
    logic                       o_busy;
    logic                       o_done;
    logic                       o_neg;
    logic                       o_err;
    logic [4*INT_DIGITS-1:0]    o_int_bcd;
    logic [4*FRAC_DIGITS-1:0]   o_frac_bcd;

    modport master (
        output i_valid, i_error, i_val,
        input  o_busy, o_done, o_neg, o_err, o_int_bcd, o_frac_bcd
    );

    modport slave (
        input  i_valid, i_error, i_val,
        output o_busy, o_done, o_neg, o_err, o_int_bcd, o_frac_bcd
    );
endinterface

// File: rtl/q_result_bcd.sv
// Signed Q(M-FRAC).FRAC to sign + packed BCD converter: serial double-dabble for the
// integer part, repeated multiply-by-ten for the truncated fraction digits.
`ifndef OUTPUTWIDTH
`define OUTPUTWIDTH 32
`endif

module q_result_bcd #(
    parameter int M           = `OUTPUTWIDTH,
    parameter int FRAC        = 8,
    parameter int INT_DIGITS  = 8,
    parameter int FRAC_DIGITS = 3
) (
    input  logic        CLK,
    input  logic        RST,
    q_result_bcd_if.slave bus
);
    localparam int IW = M - FRAC;
    localparam int IB = 4 * INT_DIGITS;
    localparam int FB = 4 * FRAC_DIGITS;
    localparam int CW = $clog2(IW + FRAC_DIGITS + 1);

    typedef enum logic [1:0] {S_IDLE, S_INT, S_FRC, S_FIN} state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_neg;
    logic            r_err;
    logic [IW-1:0]   r_int;
    logic [FRAC-1:0] r_frac;
    logic [IB-1:0]   r_bcd;
    logic [FB-1:0]   r_fbcd;
    logic            r_busy;
    logic            r_done;
    logic            r_o_neg;
    logic            r_o_err;
    logic [IB-1:0]   r_o_int;
    logic [FB-1:0]   r_o_frac;

    logic [M-1:0]    w_mag;
    logic [IB-1:0]   w_bcd_adj;
    logic [FRAC+3:0] w_f;

    assign w_mag = bus.i_val[M-1] ? -bus.i_val : bus.i_val;
    assign w_f   = {4'b0000, r_frac} * (FRAC+4)'(10);

    genvar gi;
    generate
        for (gi = 0; gi < INT_DIGITS; gi++) begin : g_dabble
            assign w_bcd_adj[4*gi +: 4] = (r_bcd[4*gi +: 4] >= 4'd5) ?
                                          r_bcd[4*gi +: 4] + 4'd3 : r_bcd[4*gi +: 4];
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_neg    <= 1'b0;
            r_err    <= 1'b0;
            r_int    <= '0;
            r_frac   <= '0;
            r_bcd    <= '0;
            r_fbcd   <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_o_neg  <= 1'b0;
            r_o_err  <= 1'b0;
            r_o_int  <= '0;
            r_o_frac <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.i_error) begin
                        // Error results spend one held cycle in FIN so done lands two edges out
                        r_err   <= 1'b1;
                        r_cnt   <= CW'(1);
                        r_busy  <= 1'b1;
                        r_state <= S_FIN;
                    end else if (bus.i_valid) begin
                        r_err   <= 1'b0;
                        r_neg   <= bus.i_val[M-1];
                        r_int   <= w_mag[M-1:FRAC];
                        r_frac  <= w_mag[FRAC-1:0];
                        r_bcd   <= '0;
                        r_fbcd  <= '0;
                        r_cnt   <= CW'(IW);
                        r_busy  <= 1'b1;
                        r_state <= S_INT;
                    end
                end
                S_INT: begin
                    r_bcd <= {w_bcd_adj[IB-2:0], r_int[IW-1]};
                    r_int <= {r_int[IW-2:0], 1'b0};
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_cnt   <= CW'(FRAC_DIGITS);
                        r_state <= S_FRC;
                    end
                end
                S_FRC: begin
                    r_fbcd <= (r_fbcd << 4) | FB'(w_f[FRAC+3:FRAC]);
                    r_frac <= w_f[FRAC-1:0];
                    r_cnt  <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_state <= S_FIN;
                    end
                end
                S_FIN: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CW'(1);
                    end else begin
                        r_o_neg  <= r_err ? 1'b0 : r_neg;
                        r_o_err  <= r_err;
                        r_o_int  <= r_err ? '0 : r_bcd;
                        r_o_frac <= r_err ? '0 : r_fbcd;
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.o_busy     = r_busy;
    assign bus.o_done     = r_done;
    assign bus.o_neg      = r_o_neg;
    assign bus.o_err      = r_o_err;
    assign bus.o_int_bcd  = r_o_int;
    assign bus.o_frac_bcd = r_o_frac;
endmodule

// File: tb/tb_q_result_bcd.sv
// Directed bench for q_result_bcd: hand-computed BCD results, latency and abort behaviour.
`timescale 1ns/1ps

module tb_q_result_bcd;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 CLK = ~CLK;

    q_result_bcd_if #(.M(32), .FRAC(8), .INT_DIGITS(8), .FRAC_DIGITS(3)) bus ();

    q_result_bcd #(.M(32), .FRAC(8), .INT_DIGITS(8), .FRAC_DIGITS(3)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, ".busy"}, {31'd0, bus.o_busy}, 32'd0);
        check({tag, ".done"}, {31'd0, bus.o_done}, 32'd0);
        check({tag, ".neg"},  {31'd0, bus.o_neg},  32'd0);
        check({tag, ".err"},  {31'd0, bus.o_err},  32'd0);
        check({tag, ".int"},  bus.o_int_bcd,        32'd0);
        check({tag, ".frac"}, {20'd0, bus.o_frac_bcd}, 32'd0);
    endtask

    // One-cycle trigger, then wait (bounded) for o_done and compare everything.
    task automatic run(input string tag, input logic [31:0] val, input logic is_err,
                       input int exp_lat, input logic exp_neg, input logic [31:0] exp_int,
                       input logic [11:0] exp_frac, input logic exp_errf);
        int lat;
        @(negedge CLK);
        bus.i_val   = val;
        bus.i_valid = !is_err;
        bus.i_error = is_err;
        @(negedge CLK);
        bus.i_valid = 1'b0;
        bus.i_error = 1'b0;
        check({tag, ".busy"}, {31'd0, bus.o_busy}, 32'd1);
        lat = 0;
        while (!bus.o_done && lat < 60) begin
            @(negedge CLK);
            lat++;
        end
        check({tag, ".lat"},  lat, exp_lat);
        check({tag, ".neg"},  {31'd0, bus.o_neg}, {31'd0, exp_neg});
        check({tag, ".int"},  bus.o_int_bcd, exp_int);
        check({tag, ".frac"}, {20'd0, bus.o_frac_bcd}, {20'd0, exp_frac});
        check({tag, ".err"},  {31'd0, bus.o_err}, {31'd0, exp_errf});
        $display("txn %s val=0x%08h lat=%0d neg=%0d int=0x%08h frac=0x%03h err=%0d",
                 tag, val, lat, bus.o_neg, bus.o_int_bcd, bus.o_frac_bcd, bus.o_err);
        @(negedge CLK);
        check({tag, ".pulse"}, {31'd0, bus.o_done}, 32'd0);
        check({tag, ".idle"},  {31'd0, bus.o_busy}, 32'd0);
    endtask

    initial begin
        int lat;
        int dones;
        bus.i_valid = 1'b0;
        bus.i_error = 1'b0;
        bus.i_val   = '0;

        repeat (3) @(negedge CLK);
        check_zero_outputs("reset");
        RST = 1'b0;

        run("int3",   32'h0000_0300, 1'b0, 28, 1'b0, 32'h0000_0003, 12'h000, 1'b0);
        run("m0p5",   32'hFFFF_FF80, 1'b0, 28, 1'b1, 32'h0000_0000, 12'h500, 1'b0);
        run("trunc",  32'h0000_0055, 1'b0, 28, 1'b0, 32'h0000_0000, 12'h332, 1'b0);
        run("maxpos", 32'h7FFF_FFFF, 1'b0, 28, 1'b0, 32'h0838_8607, 12'h996, 1'b0);
        run("maxneg", 32'h8000_0000, 1'b0, 28, 1'b1, 32'h0838_8608, 12'h000, 1'b0);
        run("error",  32'hDEAD_BEEF, 1'b1, 2,  1'b0, 32'h0000_0000, 12'h000, 1'b1);
        run("aftere", 32'h0000_0100, 1'b0, 28, 1'b0, 32'h0000_0001, 12'h000, 1'b0);

        // Second trigger 5 cycles into a conversion must be ignored.
        @(negedge CLK);
        bus.i_val   = 32'h0000_0200;
        bus.i_valid = 1'b1;
        @(negedge CLK);
        bus.i_valid = 1'b0;
        repeat (4) @(negedge CLK);
        bus.i_val   = 32'h0000_0900;
        bus.i_valid = 1'b1;
        @(negedge CLK);
        bus.i_valid = 1'b0;
        lat = 5;
        while (!bus.o_done && lat < 60) begin
            @(negedge CLK);
            lat++;
        end
        check("ignore.lat", lat, 28);
        check("ignore.int", bus.o_int_bcd, 32'h0000_0002);
        $display("txn ignore lat=%0d int=0x%08h", lat, bus.o_int_bcd);
        // run() drives on the next negedge: trigger lands in the cycle after o_done.
        run("b2b", 32'h0000_0400, 1'b0, 28, 1'b0, 32'h0000_0004, 12'h000, 1'b0);

        // Reset mid-conversion: outputs cleared and no o_done afterwards.
        @(negedge CLK);
        bus.i_val   = 32'h0000_0500;
        bus.i_valid = 1'b1;
        @(negedge CLK);
        bus.i_valid = 1'b0;
        repeat (9) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        check_zero_outputs("abort");
        dones = 0;
        repeat (40) begin
            @(negedge CLK);
            if (bus.o_done) dones++;
        end
        check("abort.dones", dones, 0);
        $display("txn abort dones=%0d", dones);
        run("postrst", 32'h0000_0AC0, 1'b0, 28, 1'b0, 32'h0000_0010, 12'h750, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
